pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the fixed per-stage registers (D/E/M/W) with one generic block. It carries PC, a packed control word and a packed data word from one stage to the next. It adds a valid/ready handshake, flush with bubble insertion, and an optional skid entry so that `in_ready` is fully registered. Each stage instantiates it with its own widths.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/pipe_slot.sv | 61 ++++++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the MIPS inter-stage pipeline registers:
//               control-word field layout, reset PC and packing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // Control word field layout, LSB first
  localparam int WRITEREG_LSB  = 0;
  localparam int WRITEREG_W    = 5;
  localparam int MEMTOREG_LSB  = 5;
  localparam int MEMTOREG_W    = 3;
  localparam int REGWRITE_BIT  = 8;
  localparam int OPCODE_LSB    = 9;
  localparam int OPCODE_W      = 6;
  localparam int FUNCT_LSB     = 15;
  localparam int FUNCT_W       = 6;
  localparam int CTRL_FIELDS_W = 21;

  typedef struct packed {
    logic [FUNCT_W-1:0]    funct;
    logic [OPCODE_W-1:0]   opcode;
    logic                  reg_write;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic [WRITEREG_W-1:0] write_reg;
  } ctrl_t;

  function automatic logic [CTRL_FIELDS_W-1:0] pack_ctrl(input ctrl_t c);
    return c;
  endfunction

  function automatic ctrl_t unpack_ctrl(input logic [CTRL_FIELDS_W-1:0] w);
    return ctrl_t'(w);
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline entry: valid bit plus pc/ctrl/data registers with
//               load, clear (clear wins) and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int          DATA_W   = 96,
  parameter int          CTRL_W   = 24,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [31:0]       i_pc,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  import pipe_pkg::*;

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // Payload holds through a clear so bubbles keep the last pc/data visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_load && !i_clear) begin
      r_pc   <= i_pc;
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic valid/ready pipeline register with flush, bubble
//               zeroing of the control word and an optional skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int          DATA_W   = 96,
  parameter int          CTRL_W   = 24,
  parameter int          SKID     = 1,
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);
  import pipe_pkg::*;

  logic              w_xfer_in;
  logic              w_xfer_out;

  logic              w_main_valid;
  logic [31:0]       w_main_pc;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_main_load;
  logic              w_main_clear;
  logic [31:0]       w_main_pc_d;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;

  logic              w_skid_valid;
  logic [31:0]       w_skid_pc;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_sel_skid;

  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = w_main_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready comes straight from the skid valid flop: no path from out_ready
      assign in_ready = !w_skid_valid;

      always_comb begin
        w_main_load  = 1'b0;
        w_skid_load  = 1'b0;
        w_main_clear = flush;
        w_skid_clear = flush;
        w_sel_skid   = 1'b0;
        if (w_xfer_out && w_skid_valid) begin
          w_main_load  = 1'b1;
          w_sel_skid   = 1'b1;
          w_skid_clear = 1'b1;
        end else if (w_xfer_in && (!w_main_valid || w_xfer_out)) begin
          w_main_load  = 1'b1;
        end else if (w_xfer_in) begin
          w_skid_load  = 1'b1;
        end else if (w_xfer_out) begin
          w_main_clear = 1'b1;
        end
      end

      pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RESET_PC (RESET_PC)
      ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (in_pc),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );
    end else begin : g_no_skid
      assign in_ready     = !w_main_valid || out_ready;
      assign w_main_load  = w_xfer_in;
      assign w_main_clear = flush || (w_xfer_out && !w_xfer_in);
      assign w_skid_load  = 1'b0;
      assign w_skid_clear = 1'b0;
      assign w_sel_skid   = 1'b0;
      assign w_skid_valid = 1'b0;
      assign w_skid_pc    = '0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
    end
  endgenerate

  assign w_main_pc_d   = w_sel_skid ? w_skid_pc   : in_pc;
  assign w_main_ctrl_d = w_sel_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_d = w_sel_skid ? w_skid_data : in_data;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RESET_PC (RESET_PC)
  ) u_main (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_pc    (w_main_pc_d),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_valid),
    .o_pc    (w_main_pc),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  // A bubble must never present RegWrite/MemWrite downstream
  assign out_valid = w_main_valid;
  assign out_pc    = w_main_pc;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
  assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule : pipe_stage_reg
`default_nettype wire
